// File: rtl/lif_cfg_sequencer_if.sv
// Host/neuron-side signal bundle for lif_cfg_sequencer.
// master: host and neuron environment that drives the sequencer.
// slave : the sequencer itself.
interface lif_cfg_sequencer_if #(
    parameter int unsigned PARAM_W = 16
) ();
    logic [PARAM_W-1:0] cfg_word;
    logic               cfg_valid;
    logic               cfg_ready;
    logic               abort;
    logic               run_req;
    logic               params_ready;
    logic               load_mode;
    logic               serial_data;
    logic               neuron_en;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output cfg_word, cfg_valid, abort, run_req, params_ready,
        input  cfg_ready, load_mode, serial_data, neuron_en, busy, done, err
    );

    modport slave (
        input  cfg_word, cfg_valid, abort, run_req, params_ready,
        output cfg_ready, load_mode, serial_data, neuron_en, busy, done, err
    );
endinterface

// File: rtl/lif_cfg_sequencer.sv
// Configuration sequencer for the LIF neuron system.
// Accepts a parallel parameter word over valid/ready, shifts it MSB-first into
// the neuron serial config port, then waits for params_ready with a timeout.
// Optional feature macro: LIF_CFG_PARITY_EN appends one even-parity bit
// (^cfg_word) after the data bits, giving PARAM_W+1 load cycles.
module lif_cfg_sequencer #(
    parameter int unsigned PARAM_W = 16,
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned TMO_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lif_cfg_sequencer_if.slave   bus
);

`ifdef LIF_CFG_PARITY_EN
    localparam int unsigned SH_W = PARAM_W + 1;
`else
    localparam int unsigned SH_W = PARAM_W;
`endif
    localparam int unsigned CNT_W = $clog2(SH_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_WAIT_RDY
    } state_t;

    state_t            state_q;
    logic [SH_W-2:0]   shift_q;      // bits still to send after the one on serial_data
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [TMO_W-1:0]  tmo_q;
    logic              cfg_ready_q;
    logic              load_mode_q;
    logic              serial_q;
    logic              neuron_en_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [SH_W-1:0]   load_word;

`ifdef LIF_CFG_PARITY_EN
    assign load_word = {bus.cfg_word, ^bus.cfg_word};
`else
    assign load_word = bus.cfg_word;
`endif

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            tmo_q       <= '0;
            cfg_ready_q <= 1'b1;
            load_mode_q <= 1'b0;
            serial_q    <= 1'b0;
            neuron_en_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.cfg_valid && cfg_ready_q) begin
                        state_q     <= S_SHIFT;
                        serial_q    <= load_word[SH_W-1];
                        shift_q     <= load_word[SH_W-2:0];
                        bit_cnt_q   <= '0;
                        load_mode_q <= 1'b1;
                        neuron_en_q <= 1'b0;
                        busy_q      <= 1'b1;
                        cfg_ready_q <= 1'b0;
                    end else begin
                        neuron_en_q <= bus.run_req;
                        cfg_ready_q <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (bus.abort) begin
                        state_q     <= S_IDLE;
                        load_mode_q <= 1'b0;
                        serial_q    <= 1'b0;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                        bit_cnt_q   <= '0;
                    end else if (bit_cnt_q == CNT_W'(SH_W - 1)) begin
                        state_q     <= S_WAIT_RDY;
                        load_mode_q <= 1'b0;
                        serial_q    <= 1'b0;
                        tmo_q       <= '0;
                        bit_cnt_q   <= '0;
                    end else begin
                        serial_q    <= shift_q[SH_W-2];
                        shift_q     <= shift_q << 1;
                        bit_cnt_q   <= bit_cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_RDY: begin
                    // abort beats params_ready, which beats the timeout
                    if (bus.abort) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                        tmo_q       <= '0;
                    end else if (bus.params_ready) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                        done_q      <= 1'b1;
                        tmo_q       <= '0;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        cfg_ready_q <= 1'b1;
                        err_q       <= 1'b1;
                        tmo_q       <= '0;
                    end else begin
                        tmo_q       <= tmo_q + TMO_W'(1);
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    load_mode_q <= 1'b0;
                    serial_q    <= 1'b0;
                    busy_q      <= 1'b0;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cfg_ready   = cfg_ready_q;
    assign bus.load_mode   = load_mode_q;
    assign bus.serial_data = serial_q;
    assign bus.neuron_en   = neuron_en_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_lif_cfg_sequencer.sv
// Scoreboard bench for lif_cfg_sequencer: the driver plans each load, derives
// the expected bit stream, wait length and outcome, and queues it; the monitor
// measures each busy episode and compares when the sequencer returns to idle.
module tb_lif_cfg_sequencer;
    localparam int unsigned PW  = 16;
    localparam int unsigned TMO = 200;
    localparam int unsigned TW  = 8;
`ifdef LIF_CFG_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int unsigned N = PW + (PAR ? 1 : 0);

    typedef struct {
        int unsigned nload;
        logic [31:0] bits;
        int unsigned nwait;
        logic        done;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mon_en = 1'b0;
    logic sb_busy = 1'b0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    exp_t sb_q[$];

    lif_cfg_sequencer_if #(.PARAM_W(PW)) bus ();

    lif_cfg_sequencer #(.PARAM_W(PW), .TIMEOUT(TMO), .TMO_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Full serial stream for a word: data MSB first, then parity if enabled.
    function automatic logic [31:0] stream(input logic [PW-1:0] w);
        logic [31:0] s;
        s = 32'(w);
        if (PAR) s = (s << 1) | 32'(^w);
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        chk("rst_load_mode", 32'(bus.load_mode), 32'd0);
        chk("rst_serial", 32'(bus.serial_data), 32'd0);
        chk("rst_neuron_en", 32'(bus.neuron_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            sb_busy          = 1'b0;
            bus.cfg_valid    = 1'b0;
            bus.cfg_word     = PW'($urandom);
            bus.abort        = 1'($urandom);
            bus.run_req      = 1'($urandom);
            bus.params_ready = 1'($urandom);
            step();
        end
    endtask

    // d: WAIT cycle (1-based) with params_ready high, 0 = never.
    // a: cycle after the handshake (1-based) with abort high, 0 = none.
    task automatic run_txn(input logic [PW-1:0] w, input int unsigned d,
                           input int unsigned a, input int unsigned idle_n);
        exp_t e;
        int unsigned wd, end_c, ab;
        idle(idle_n);
        wd    = (d != 0 && d <= TMO) ? d : TMO;
        end_c = N + wd;
        ab    = a;
        if (ab != 0 && ab <= end_c) begin
            e.nload = (ab < N) ? ab : N;
            e.nwait = (ab > N) ? ab - N : 0;
            e.done  = 1'b0;
            e.err   = 1'b0;
            end_c   = ab;
        end else begin
            ab      = 0;
            e.nload = N;
            e.nwait = wd;
            e.done  = (d != 0 && d <= TMO);
            e.err   = !(d != 0 && d <= TMO);
        end
        e.bits = stream(w) >> (N - e.nload);
        sb_q.push_back(e);
        sb_busy          = 1'b0;
        bus.cfg_valid    = 1'b1;
        bus.cfg_word     = w;
        bus.abort        = 1'($urandom);
        bus.run_req      = 1'($urandom);
        bus.params_ready = 1'($urandom);
        step();
        for (int unsigned c = 1; c <= end_c; c++) begin
            sb_busy          = 1'b1;
            bus.cfg_valid    = 1'($urandom);
            bus.cfg_word     = PW'($urandom);
            bus.abort        = (c == ab);
            bus.run_req      = 1'($urandom);
            bus.params_ready = (c <= N) ? 1'($urandom) : (d != 0 && c == N + d);
            step();
        end
    endtask

    // Monitor: measure each busy episode, compare against the queue on return to idle.
    logic        active = 1'b0;
    int unsigned m_nload = 0;
    int unsigned m_nwait = 0;
    logic [31:0] m_bits = '0;
    logic        p_rst = 1'b0, p_busy = 1'b0, p_valid = 1'b0, p_run = 1'b0;
    exp_t        e_m;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("neuron_en", 32'(bus.neuron_en),
                32'((p_rst && !p_busy && !p_valid) ? p_run : 1'b0));
            chk("cfg_ready", 32'(bus.cfg_ready), 32'(!sb_busy));
            chk("busy", 32'(bus.busy), 32'(sb_busy));
            if (bus.busy) begin
                active = 1'b1;
                chk("done_while_busy", 32'(bus.done), 32'd0);
                chk("err_while_busy", 32'(bus.err), 32'd0);
                if (bus.load_mode) begin
                    m_nload++;
                    m_bits = {m_bits[30:0], bus.serial_data};
                end else begin
                    m_nwait++;
                    chk("serial_in_wait", 32'(bus.serial_data), 32'd0);
                end
            end else begin
                chk("load_mode_idle", 32'(bus.load_mode), 32'd0);
                chk("serial_idle", 32'(bus.serial_data), 32'd0);
                if (active) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_unexpected_load", 32'd1, 32'd0);
                    end else begin
                        e_m = sb_q.pop_front();
                        chk("load_cycles", m_nload, e_m.nload);
                        chk("load_bits", m_bits, e_m.bits);
                        chk("wait_cycles", m_nwait, e_m.nwait);
                        chk("done_pulse", 32'(bus.done), 32'(e_m.done));
                        chk("err_pulse", 32'(bus.err), 32'(e_m.err));
                    end
                    active  = 1'b0;
                    m_nload = 0;
                    m_nwait = 0;
                    m_bits  = '0;
                end else begin
                    chk("done_quiet", 32'(bus.done), 32'd0);
                    chk("err_quiet", 32'(bus.err), 32'd0);
                end
            end
        end
        p_rst   = rst_n;
        p_busy  = sb_busy;
        p_valid = bus.cfg_valid;
        p_run   = bus.run_req;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned r, d, a;
        bus.cfg_word     = '0;
        bus.cfg_valid    = 1'b0;
        bus.abort        = 1'b0;
        bus.run_req      = 1'b1;
        bus.params_ready = 1'b0;
        rst_n            = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        run_txn(16'hA5C3, 3, 0, 1);
        run_txn(16'h1234, 0, 0, 0);
        run_txn(16'hBEEF, 0, 5, 2);
        run_txn(16'h0F0F, 2, 0, 0);
        run_txn(16'h5555, TMO, 0, 1);
        run_txn(16'h0001, 1, 0, 1);
        run_txn(16'hFFFF, 4, N + 2, 1);
        run_txn(16'h8000, 3, N + 3, 0);
        run_txn(16'h7E81, 1, N, 2);
        for (int i = 0; i < 50; i++) begin
            r = $urandom % 20;
            d = (r == 0) ? 0 : (r == 1) ? TMO : 1 + $urandom % 8;
            a = ($urandom % 5 == 0) ? 1 + $urandom % (N + 4) : 0;
            run_txn(PW'($urandom), d, a, $urandom % 3);
        end
        idle(3);
        chk("sb_drained", sb_q.size(), 32'd0);

        // Reset in the middle of a load.
        mon_en           = 1'b0;
        bus.cfg_valid    = 1'b1;
        bus.cfg_word     = 16'h0001;
        bus.abort        = 1'b0;
        bus.params_ready = 1'b0;
        bus.run_req      = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        repeat (5) step();
        chk("load_mode_mid_shift", 32'(bus.load_mode), 32'd1);
        chk("busy_mid_shift", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        step();
        check_reset_vals();
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
